btn_reset_conditioner: RTL and testbench

Multi-channel push-button front end for the RISC-V top: synchronises and debounces N_BTN raw board buttons, emits clean levels plus one-cycle press and release pulses, and generates the stretched core reset. One channel is the core reset request. This replaces direct use of a raw button as the core reset; the core sees only a glitch-free, synchronously deasserted core_rst.

---
 rtl/btn_reset_conditioner.sv | 164 ++++++++++++++++
 tb/tb_btn_reset_conditioner.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/btn_reset_conditioner.sv
// Push-button front end: per-channel sync + debounce with edge pulses, plus the stretched core reset.
// Optional long-press detection is compiled in when LONG_PRESS_EN is defined.
module btn_reset_conditioner #(
  parameter int N_BTN           = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int RST_STRETCH     = 16,
  parameter int RESET_CH        = 0,
  parameter int LONG_CYCLES     = 25000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_rise,
  output logic [N_BTN-1:0] btn_fall,
  output logic [N_BTN-1:0] btn_long,
  output logic             core_rst
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = $clog2(RST_STRETCH + 1);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] STR_MAX = SW'(RST_STRETCH - 1);

  typedef enum logic [0:0] {
    RST_HOLD = 1'b0,
    RUN      = 1'b1
  } rst_state_e;

  if (N_BTN < 1 || DEBOUNCE_CYCLES < 1 || RST_STRETCH < 1 || LONG_CYCLES < 1 ||
      RESET_CH < 0 || RESET_CH >= N_BTN) begin : g_param_check
    $error("btn_reset_conditioner: illegal parameter value");
  end

  logic [N_BTN-1:0] sync_s1;
  logic [N_BTN-1:0] sync_s2;

  // Plain two-flop synchroniser; nothing may sit between the stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_s1 <= '0;
      sync_s2 <= '0;
    end else begin
      sync_s1 <= btn;
      sync_s2 <= sync_s1;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic [DW-1:0] deb_cnt;
    logic          level_q;
    logic          rise_q;
    logic          fall_q;

    // Pulses are registered alongside the level so they line up with its new value.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        deb_cnt <= '0;
        level_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        if (sync_s2[i] == level_q) begin
          deb_cnt <= '0;
        end else if (deb_cnt == DEB_MAX) begin
          deb_cnt <= '0;
          level_q <= ~level_q;
          rise_q  <= ~level_q;
          fall_q  <= level_q;
        end else begin
          deb_cnt <= deb_cnt + DW'(1);
        end
      end
    end

    assign btn_level[i] = level_q;
    assign btn_rise[i]  = rise_q;
    assign btn_fall[i]  = fall_q;

`ifdef LONG_PRESS_EN
    localparam int LW = $clog2(LONG_CYCLES + 1);
    localparam logic [LW-1:0] LONG_SAT = LW'(LONG_CYCLES);
    localparam logic [LW-1:0] LONG_HIT = LW'(LONG_CYCLES - 1);

    logic [LW-1:0] long_cnt;
    logic          long_q;

    // Saturating at LONG_CYCLES keeps the hit value from recurring during one press.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        long_cnt <= '0;
        long_q   <= 1'b0;
      end else begin
        long_q <= level_q && (long_cnt == LONG_HIT);
        if (!level_q) begin
          long_cnt <= '0;
        end else if (long_cnt != LONG_SAT) begin
          long_cnt <= long_cnt + LW'(1);
        end
      end
    end

    assign btn_long[i] = long_q;
`else
    assign btn_long[i] = 1'b0;
`endif
  end

  rst_state_e    state_q, state_d;
  logic [SW-1:0] str_q, str_d;
  logic          core_rst_q, core_rst_d;
  logic          rst_level;
  logic          rst_rise;

  assign rst_level = btn_level[RESET_CH];
  assign rst_rise  = btn_rise[RESET_CH];

  // core_rst is a flop set by rst_n asynchronously and released only on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RST_HOLD;
      str_q      <= '0;
      core_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      str_q      <= str_d;
      core_rst_q <= core_rst_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    str_d      = str_q;
    core_rst_d = 1'b1;
    unique case (state_q)
      RST_HOLD: begin
        if (rst_level) begin
          str_d = '0;
        end else if (str_q == STR_MAX) begin
          state_d = RUN;
          str_d   = '0;
        end else begin
          str_d = str_q + SW'(1);
        end
      end
      RUN: begin
        if (rst_rise) begin
          state_d = RST_HOLD;
          str_d   = '0;
        end
      end
      default: begin
        state_d = RST_HOLD;
        str_d   = '0;
      end
    endcase
    core_rst_d = (state_d == RST_HOLD);
  end

  assign core_rst = core_rst_q;

endmodule

// File: tb/tb_btn_reset_conditioner.sv
// Directed bench for btn_reset_conditioner with DEBOUNCE_CYCLES=4, RST_STRETCH=8, LONG_CYCLES=16.
// Long-press expectations follow LONG_PRESS_EN.
module tb_btn_reset_conditioner;

  logic       clk;
  logic       rst_n;
  logic [1:0] btn;
  logic [1:0] btn_level;
  logic [1:0] btn_rise;
  logic [1:0] btn_fall;
  logic [1:0] btn_long;
  logic       core_rst;

  int checks;
  int errors;

  btn_reset_conditioner #(
    .N_BTN(2),
    .DEBOUNCE_CYCLES(4),
    .RST_STRETCH(8),
    .RESET_CH(0),
    .LONG_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn(btn),
    .btn_level(btn_level),
    .btn_rise(btn_rise),
    .btn_fall(btn_fall),
    .btn_long(btn_long),
    .core_rst(core_rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] value);
    btn = value;
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  // {level, rise, fall} packed for compact per-edge comparisons
  function automatic logic [31:0] pack3(input logic [1:0] l, input logic [1:0] r, input logic [1:0] f);
    return {26'd0, l, r, f};
  endfunction

  initial begin
    logic [1:0] expLong;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    btn    = 2'b00;

    // Test 1: power-on reset and stretch
    repeat (3) stepEdge();
    checkOutput("t1_rst_core", {31'd0, core_rst}, 32'd1);
    checkOutput("t1_rst_outs", {24'd0, btn_level, btn_rise, btn_fall, btn_long}, 32'd0);
    rst_n = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      stepEdge();
      checkOutput($sformatf("t1_core_e%0d", e), {31'd0, core_rst}, (e < 8) ? 32'd1 : 32'd0);
      checkOutput($sformatf("t1_outs_e%0d", e), {24'd0, btn_level, btn_rise, btn_fall, btn_long}, 32'd0);
    end

    // Test 2: clean press and release on channel 1
    applyStimulus(2'b10);
    for (int e = 1; e <= 7; e++) begin
      stepEdge();
      checkOutput($sformatf("t2_press_e%0d", e), pack3(btn_level, btn_rise, btn_fall),
                  pack3((e >= 6) ? 2'b10 : 2'b00, (e == 6) ? 2'b10 : 2'b00, 2'b00));
      checkOutput($sformatf("t2_core_e%0d", e), {31'd0, core_rst}, 32'd0);
    end
    applyStimulus(2'b00);
    for (int e = 1; e <= 7; e++) begin
      stepEdge();
      checkOutput($sformatf("t2_release_e%0d", e), pack3(btn_level, btn_rise, btn_fall),
                  pack3((e < 6) ? 2'b10 : 2'b00, 2'b00, (e == 6) ? 2'b10 : 2'b00));
    end

    // Test 3: bounce never reaches the threshold
    begin
      logic [4:0] pattern;
      pattern = 5'b01101;
      for (int e = 1; e <= 13; e++) begin
        applyStimulus((e <= 5) ? {pattern[e-1], 1'b0} : 2'b00);
        stepEdge();
        checkOutput($sformatf("t3_bounce_e%0d", e), pack3(btn_level, btn_rise, btn_fall), 32'd0);
      end
    end

    // Test 4: reset button held in RUN, then released
    applyStimulus(2'b01);
    for (int e = 1; e <= 20; e++) begin
      stepEdge();
      checkOutput($sformatf("t4_hold_core_e%0d", e), {31'd0, core_rst}, (e >= 7) ? 32'd1 : 32'd0);
      checkOutput($sformatf("t4_hold_ch0_e%0d", e), {30'd0, btn_level[0], btn_rise[0]},
                  {30'd0, (e >= 6), (e == 6)});
    end
    applyStimulus(2'b00);
    for (int e = 1; e <= 15; e++) begin
      stepEdge();
      checkOutput($sformatf("t4_rel_core_e%0d", e), {31'd0, core_rst}, (e < 14) ? 32'd1 : 32'd0);
      checkOutput($sformatf("t4_rel_ch0_e%0d", e), {30'd0, btn_level[0], btn_fall[0]},
                  {30'd0, (e < 6), (e == 6)});
    end

    // Test 5: rst_n mid-debounce
    applyStimulus(2'b10);
    repeat (4) stepEdge();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t5_async_core", {31'd0, core_rst}, 32'd1);
    checkOutput("t5_async_outs", {24'd0, btn_level, btn_rise, btn_fall, btn_long}, 32'd0);
    applyStimulus(2'b00);
    repeat (2) stepEdge();
    checkOutput("t5_held_core", {31'd0, core_rst}, 32'd1);
    rst_n = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      stepEdge();
      checkOutput($sformatf("t5_core_e%0d", e), {31'd0, core_rst}, (e < 8) ? 32'd1 : 32'd0);
      checkOutput($sformatf("t5_outs_e%0d", e), {24'd0, btn_level, btn_rise, btn_fall, btn_long}, 32'd0);
    end

    // Test 6: simultaneous edges on both channels
    applyStimulus(2'b11);
    for (int e = 1; e <= 7; e++) begin
      stepEdge();
      checkOutput($sformatf("t6_press_e%0d", e), pack3(btn_level, btn_rise, btn_fall),
                  pack3((e >= 6) ? 2'b11 : 2'b00, (e == 6) ? 2'b11 : 2'b00, 2'b00));
      checkOutput($sformatf("t6_press_core_e%0d", e), {31'd0, core_rst}, (e >= 7) ? 32'd1 : 32'd0);
    end
    applyStimulus(2'b00);
    for (int e = 1; e <= 15; e++) begin
      stepEdge();
      checkOutput($sformatf("t6_rel_e%0d", e), pack3(btn_level, btn_rise, btn_fall),
                  pack3((e < 6) ? 2'b11 : 2'b00, 2'b00, (e == 6) ? 2'b11 : 2'b00));
      checkOutput($sformatf("t6_rel_core_e%0d", e), {31'd0, core_rst}, (e < 14) ? 32'd1 : 32'd0);
    end

    // Test 7: long press on channel 1
    applyStimulus(2'b10);
    for (int e = 1; e <= 40; e++) begin
      stepEdge();
`ifdef LONG_PRESS_EN
      expLong = (e == 22) ? 2'b10 : 2'b00;
`else
      expLong = 2'b00;
`endif
      checkOutput($sformatf("t7_long_e%0d", e), {30'd0, btn_long}, {30'd0, expLong});
      checkOutput($sformatf("t7_core_e%0d", e), {31'd0, core_rst}, 32'd0);
    end
    applyStimulus(2'b00);
    for (int e = 1; e <= 8; e++) begin
      stepEdge();
      checkOutput($sformatf("t7_rel_long_e%0d", e), {30'd0, btn_long}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
